// File: rtl/axi_lite_sram.sv
// axi_lite_sram: word-organised data SRAM answering AXI-lite AR/R and AW/W/B channels.
// Latency: rvalid RD_LATENCY cycles after AR accept; bvalid WR_LATENCY cycles after AW+W accept.
// Backpressure: rvalid/bvalid hold with stable payload until rready/bready; no new request is taken meanwhile.
module axi_lite_sram #(
  parameter int unsigned            DATA_WIDTH = 32,
  parameter int unsigned            ADDR_WIDTH = 32,
  parameter int unsigned            DEPTH_LOG2 = 12,
  parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR  = 32'h8000_0000,
  parameter int unsigned            RD_LATENCY = 1,
  parameter int unsigned            WR_LATENCY = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [ADDR_WIDTH-1:0]     araddr,
  input  logic                      arvalid,
  output logic                      arready,
  output logic [DATA_WIDTH-1:0]     rdata,
  output logic [1:0]                rresp,
  output logic                      rvalid,
  input  logic                      rready,
  input  logic [ADDR_WIDTH-1:0]     awaddr,
  input  logic                      awvalid,
  output logic                      awready,
  input  logic [DATA_WIDTH-1:0]     wdata,
  input  logic [DATA_WIDTH/8-1:0]   wstrb,
  input  logic                      wvalid,
  output logic                      wready,
  output logic [1:0]                bresp,
  output logic                      bvalid,
  input  logic                      bready
);

  localparam int                    STRB_W  = DATA_WIDTH / 8;
  localparam int unsigned           WORDS   = 1 << DEPTH_LOG2;
  localparam logic [ADDR_WIDTH:0]   LO_ADDR = {1'b0, BASE_ADDR};
  localparam logic [ADDR_WIDTH:0]   HI_ADDR = LO_ADDR + (ADDR_WIDTH+1)'(WORDS * 4);
  localparam logic [1:0]            RESP_OKAY   = 2'b00;
  localparam logic [1:0]            RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;

  // Storage: deliberately unreset, contents are loaded by software or test.
  logic [DATA_WIDTH-1:0] mem [0:WORDS-1];

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return ({1'b0, a} >= LO_ADDR) && ({1'b0, a} < HI_ADDR);
  endfunction

  // ---------------- read path ----------------
  r_state_t              r_state_q, r_state_d;
  logic [3:0]            r_cnt_q, r_cnt_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic                  arready_q, arready_d;
  logic                  rvalid_q, rvalid_d;
  logic [DEPTH_LOG2-1:0] r_idx;
  logic [DATA_WIDTH-1:0] r_word;

  assign r_idx  = araddr_q[DEPTH_LOG2+1:2];
  assign r_word = mem[r_idx];

  // Read next-state: latch request, count down latency, then present shifted word until rready.
  always_comb begin
    r_state_d = r_state_q;
    r_cnt_d   = r_cnt_q;
    araddr_d  = araddr_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    unique case (r_state_q)
      R_IDLE: begin
        if (arvalid && arready_q) begin
          araddr_d  = araddr;
          r_cnt_d   = 4'(RD_LATENCY - 1);
          r_state_d = R_WAIT;
        end
      end
      R_WAIT: begin
        if (r_cnt_q == 4'd0) begin
          if (in_range(araddr_q)) begin
            rdata_d = r_word >> {araddr_q[1:0], 3'b000};
            rresp_d = RESP_OKAY;
          end else begin
            rdata_d = '0;
            rresp_d = RESP_SLVERR;
          end
          r_state_d = R_RESP;
        end else begin
          r_cnt_d = r_cnt_q - 4'd1;
        end
      end
      R_RESP: begin
        if (rready) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
    arready_d = (r_state_d == R_IDLE);
    rvalid_d  = (r_state_d == R_RESP);
  end

  // Read state and registered channel outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state_q <= R_IDLE;
      r_cnt_q   <= '0;
      araddr_q  <= '0;
      rdata_q   <= '0;
      rresp_q   <= '0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      r_cnt_q   <= r_cnt_d;
      araddr_q  <= araddr_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
    end
  end

  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;

  // ---------------- write path ----------------
  w_state_t              w_state_q, w_state_d;
  logic [3:0]            w_cnt_q, w_cnt_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]     wstrb_q, wstrb_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  awready_q, awready_d;
  logic                  bvalid_q, bvalid_d;
  logic                  w_commit;
  logic                  w_ok;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic [DATA_WIDTH-1:0] w_lane_dat;
  logic [STRB_W-1:0]     w_lane_en;

  assign w_ok       = in_range(awaddr_q);
  assign w_commit   = (w_state_q == W_WAIT) && (w_cnt_q == 4'd0);
  assign w_idx      = awaddr_q[DEPTH_LOG2+1:2];
  // Lanes shifted past the top of the word fall off; a store never spills into the next word.
  assign w_lane_dat = wdata_q << {awaddr_q[1:0], 3'b000};
  assign w_lane_en  = wstrb_q << awaddr_q[1:0];

  // Write next-state: accept only joint AW+W, count down latency, commit, then hold B until bready.
  always_comb begin
    w_state_d = w_state_q;
    w_cnt_d   = w_cnt_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bresp_d   = bresp_q;
    unique case (w_state_q)
      W_IDLE: begin
        if (awvalid && wvalid && awready_q) begin
          awaddr_d  = awaddr;
          wdata_d   = wdata;
          wstrb_d   = wstrb;
          w_cnt_d   = 4'(WR_LATENCY - 1);
          w_state_d = W_WAIT;
        end
      end
      W_WAIT: begin
        if (w_cnt_q == 4'd0) begin
          bresp_d   = w_ok ? RESP_OKAY : RESP_SLVERR;
          w_state_d = W_RESP;
        end else begin
          w_cnt_d = w_cnt_q - 4'd1;
        end
      end
      W_RESP: begin
        if (bready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
    awready_d = (w_state_d == W_IDLE);
    bvalid_d  = (w_state_d == W_RESP);
  end

  // Write state and registered channel outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state_q <= W_IDLE;
      w_cnt_q   <= '0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bresp_q   <= '0;
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      w_cnt_q   <= w_cnt_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bresp_q   <= bresp_d;
      awready_q <= awready_d;
      bvalid_q  <= bvalid_d;
    end
  end

  // Byte-lane array update; a same-cycle read sample still sees the pre-write word.
  always_ff @(posedge clk) begin
    if (w_commit && w_ok && rst_n) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (w_lane_en[b]) mem[w_idx][8*b +: 8] <= w_lane_dat[8*b +: 8];
      end
    end
  end

  assign awready = awready_q;
  assign wready  = awready_q;
  assign bvalid  = bvalid_q;
  assign bresp   = bresp_q;

endmodule
